// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding, mem_size codes
// and the alignment rule used by both the arbiter and the lane formatter.
package bus_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = WORD_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_MEM   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Size code 3 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/bus_lane_formatter.sv
// Combinational byte-lane handling: write strobes, store data replication,
// load extraction with sign/zero extension, and the misalignment check.
module bus_lane_formatter
  import bus_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic              sign_ext,
  input  logic [WORD_W-1:0] store_data,
  input  logic [WORD_W-1:0] read_data,
  output logic [STRB_W-1:0] strobe,
  output logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] load_data,
  output logic              misaligned
);

  logic [WORD_W-1:0] shifted;

  always_comb begin
    shifted    = read_data >> {addr_lo, 3'b000};
    strobe     = 4'b1111;
    write_data = store_data;
    load_data  = shifted;
    case (size)
      SIZE_BYTE: begin
        strobe     = 4'b0001 << addr_lo;
        write_data = {4{store_data[7:0]}};
        load_data  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        strobe     = 4'b0011 << {addr_lo[1], 1'b0};
        write_data = {2{store_data[15:0]}};
        load_data  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

  assign misaligned = is_misaligned(size, addr_lo);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between instruction fetch and data access onto one
// external bus. Optional ext_ready timeout is enabled with BUS_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_address,
  output logic        fetch_ready,
  output logic [31:0] fetch_data,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  output logic        mem_ready,
  output logic [31:0] mem_load_data,
  output logic        mem_misaligned,
  output logic        ext_valid,
  output logic        ext_instruction,
  input  logic        ext_ready,
  output logic [31:0] ext_address,
  output logic [31:0] ext_write_data,
  output logic [3:0]  ext_write_strobe,
  input  logic [31:0] ext_read_data,
  output logic        bus_error
);

  state_t      state;
  logic        last_fetch;
  logic        lat_fetch;
  logic        lat_write;
  logic        lat_signed;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;

  logic        mem_req;
  logic        grant_fetch;
  logic        grant_mem;
  logic [3:0]  fmt_strobe;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_load;
  logic        fmt_mis;

`ifdef BUS_TIMEOUT_EN
  logic [15:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT_CYCLES);
`endif

  // On a tie the requester that did not win the previous grant goes first.
  assign mem_req     = mem_load | mem_store;
  assign grant_fetch = fetch_valid & (~mem_req | ~last_fetch);
  assign grant_mem   = mem_req & (~fetch_valid | last_fetch);

  bus_lane_formatter u_fmt (
    .size       (lat_size),
    .addr_lo    (lat_addr[1:0]),
    .sign_ext   (lat_signed),
    .store_data (lat_data),
    .read_data  (ext_read_data),
    .strobe     (fmt_strobe),
    .write_data (fmt_wdata),
    .load_data  (fmt_load),
    .misaligned (fmt_mis)
  );

  assign ext_instruction  = lat_fetch;
  assign ext_address      = {lat_addr[31:2], 2'b00};
  assign ext_write_data   = fmt_wdata;
  assign ext_write_strobe = lat_write ? fmt_strobe : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      last_fetch     <= 1'b1;
      lat_fetch      <= 1'b0;
      lat_write      <= 1'b0;
      lat_signed     <= 1'b0;
      lat_size       <= 2'd0;
      lat_addr       <= '0;
      lat_data       <= '0;
      ext_valid      <= 1'b0;
      fetch_ready    <= 1'b0;
      fetch_data     <= '0;
      mem_ready      <= 1'b0;
      mem_load_data  <= '0;
      mem_misaligned <= 1'b0;
      bus_error      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      to_cnt         <= '0;
`endif
    end else begin
      fetch_ready    <= 1'b0;
      mem_ready      <= 1'b0;
      mem_misaligned <= 1'b0;
      bus_error      <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef BUS_TIMEOUT_EN
          to_cnt <= '0;
`endif
          if (grant_fetch) begin
            state      <= ST_FETCH;
            last_fetch <= 1'b1;
            lat_fetch  <= 1'b1;
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= SIZE_WORD;
            lat_addr   <= fetch_address;
            lat_data   <= '0;
            ext_valid  <= 1'b1;
          end else if (grant_mem) begin
            state      <= ST_MEM;
            last_fetch <= 1'b0;
            lat_fetch  <= 1'b0;
            lat_write  <= mem_store;
            lat_signed <= mem_signed;
            lat_size   <= mem_size;
            lat_addr   <= mem_address;
            lat_data   <= mem_store_data;
            // A misaligned access never reaches the bus.
            ext_valid  <= ~is_misaligned(mem_size, mem_address[1:0]);
          end
        end
        ST_FETCH, ST_MEM: begin
          if (!lat_fetch && fmt_mis) begin
            state          <= ST_RESP;
            ext_valid      <= 1'b0;
            mem_ready      <= 1'b1;
            mem_misaligned <= 1'b1;
            mem_load_data  <= '0;
          end else if (ext_ready) begin
            state     <= ST_RESP;
            ext_valid <= 1'b0;
            if (lat_fetch) begin
              fetch_ready <= 1'b1;
              fetch_data  <= ext_read_data;
            end else begin
              mem_ready     <= 1'b1;
              mem_load_data <= fmt_load;
            end
          end
`ifdef BUS_TIMEOUT_EN
          else if (to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state     <= ST_RESP;
            ext_valid <= 1'b0;
            bus_error <= 1'b1;
            if (lat_fetch) begin
              fetch_ready <= 1'b1;
              fetch_data  <= '0;
            end else begin
              mem_ready     <= 1'b1;
              mem_load_data <= '0;
            end
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, corner-case
// sequences (round-robin, reset mid-transfer, long wait/timeout) and random traffic.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_address = '0;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        mem_load = 1'b0;
  logic        mem_store = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_store_data = '0;
  logic [1:0]  mem_size = '0;
  logic        mem_signed = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_load_data;
  logic        mem_misaligned;
  logic        ext_valid;
  logic        ext_instruction;
  logic        ext_ready = 1'b0;
  logic [31:0] ext_address;
  logic [31:0] ext_write_data;
  logic [3:0]  ext_write_strobe;
  logic [31:0] ext_read_data = '0;
  logic        bus_error;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_address(fetch_address),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .mem_load(mem_load), .mem_store(mem_store), .mem_address(mem_address),
    .mem_store_data(mem_store_data), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_ready(mem_ready), .mem_load_data(mem_load_data), .mem_misaligned(mem_misaligned),
    .ext_valid(ext_valid), .ext_instruction(ext_instruction), .ext_ready(ext_ready),
    .ext_address(ext_address), .ext_write_data(ext_write_data),
    .ext_write_strobe(ext_write_strobe), .ext_read_data(ext_read_data),
    .bus_error(bus_error)
  );

  typedef struct {
    logic        fetch;
    logic        load;
    logic        store;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic [3:0]  e_strb;
    logic        e_mis;
    logic        chk_data;
  } vec_t;

  typedef struct {
    logic        got;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        instr;
    logic [31:0] data;
    logic        fr;
    logic        mr;
    logic        mis;
    logic        err;
    int          nvalid;
    int          lat;
  } obs_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        mis;
  } exp_t;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Reference: derived from access size and byte offset with plain arithmetic.
  function automatic exp_t model(input logic fetch, input logic store, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input logic [1:0] size, input logic sgn);
    exp_t   e;
    int     nb;
    int     off;
    longint v;
    nb  = fetch ? 4 : (size == 2'd0 ? 1 : (size == 2'd1 ? 2 : 4));
    off = int'(addr % 4);
    e.addr = addr - 32'(off);
    e.mis  = !fetch && (off % nb != 0);
    e.strb = (fetch || !store) ? 4'b0000 : 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
    if (fetch) e.data = rdata;
    else if (e.mis) e.data = 32'h0;
    else begin
      v = longint'(rdata) >> (8 * off);
      if (nb < 4) begin
        v = v % (longint'(1) << (8 * nb));
        if (sgn && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      end
      e.data = 32'(v);
    end
    return e;
  endfunction

  // One transaction from IDLE; the bus answers after wt stalled cycles.
  task automatic run_txn(input logic fetch, input logic load, input logic store,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sgn,
                         input logic [31:0] rdata, input int wt, output obs_t o);
    int cyc;
    o = '{default: 0};
    @(negedge clk);
    fetch_valid = fetch; fetch_address = addr;
    mem_load = load; mem_store = store; mem_address = addr;
    mem_store_data = wdata; mem_size = size; mem_signed = sgn;
    ext_read_data = rdata;
    cyc = 1;
    while (!o.got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ext_valid) begin
        if (o.nvalid == 0) begin
          o.addr = ext_address; o.wdata = ext_write_data;
          o.strb = ext_write_strobe; o.instr = ext_instruction;
        end
        o.nvalid++;
        ext_ready = (o.nvalid > wt);
      end else ext_ready = 1'b0;
      if (fetch_ready || mem_ready) begin
        o.got = 1'b1; o.lat = cyc; o.fr = fetch_ready; o.mr = mem_ready;
        o.data = fetch_ready ? fetch_data : mem_load_data;
        o.mis = mem_misaligned; o.err = bus_error;
      end
    end
    fetch_valid = 1'b0; mem_load = 1'b0; mem_store = 1'b0; ext_ready = 1'b0;
    check32("txn_done", 32'(o.got), 32'd1);
  endtask

  task automatic check_txn(input string tag, input logic fetch, input logic store, input obs_t o,
                           input exp_t e, input logic chk_data, input int wt);
    check32({tag, "_kind"}, {30'b0, o.fr, o.mr}, fetch ? 32'd2 : 32'd1);
    check32({tag, "_mis"}, 32'(o.mis), 32'(e.mis));
    check32({tag, "_nvalid"}, 32'(o.nvalid), e.mis ? 32'd0 : 32'(wt + 1));
    check32({tag, "_lat"}, 32'(o.lat), e.mis ? 32'd3 : 32'(wt + 3));
    check32({tag, "_err"}, 32'(o.err), 32'd0);
    if (!e.mis) begin
      check32({tag, "_addr"}, o.addr, e.addr);
      check32({tag, "_instr"}, 32'(o.instr), 32'(fetch));
      check32({tag, "_strb"}, 32'(o.strb), 32'(e.strb));
      if (store) check32({tag, "_wdata"}, o.wdata, e.wdata);
    end
    if (chk_data) check32({tag, "_data"}, o.data, e.data);
  endtask

  vec_t tv[13];

  initial begin
    obs_t o;
    exp_t e;
    int   k;
    int   cyc;
    logic saw;

    tv[0]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0, 32'h0000_0013,
               32'h8000_0000, 32'h0, 32'h0000_0013, 4'b0000, 1'b0, 1'b1};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'h8000_0000,
               32'h0000_1000, 32'h0, 32'hFFFF_FF80, 4'b0000, 1'b0, 1'b1};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h8000_0000,
               32'h0000_1000, 32'h0, 32'h0000_0080, 4'b0000, 1'b0, 1'b1};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h0,
               32'h0000_2000, 32'hBEEF_BEEF, 32'h0, 4'b1100, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_2001, 32'h0, 32'h1234_5678,
               32'h0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_3002, 32'h0, 32'h8001_1234,
               32'h0000_3000, 32'h0, 32'hFFFF_8001, 4'b0000, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_4001, 32'h0000_00A5, 32'h0,
               32'h0000_4000, 32'hA5A5_A5A5, 32'h0, 4'b0010, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_5000, 32'h1234_5678, 32'h0,
               32'h0000_5000, 32'h1234_5678, 32'h0, 4'b1111, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_2001, 32'h0000_BEEF, 32'h0,
               32'h0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_6000, 32'h0, 32'hDEAD_BEEF,
               32'h0000_6000, 32'h0, 32'hDEAD_BEEF, 4'b0000, 1'b0, 1'b1};
    tv[10] = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_7004, 32'hCAFE_F00D, 32'h0,
               32'h0000_7004, 32'hCAFE_F00D, 32'h0, 4'b1111, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_3000, 32'h0, 32'h1234_F00D,
               32'h0000_3000, 32'h0, 32'h0000_F00D, 4'b0000, 1'b0, 1'b1};
    tv[12] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_1001, 32'h0, 32'h0000_7F00,
               32'h0000_1000, 32'h0, 32'h0000_007F, 4'b0000, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check32("rst_ext_valid", 32'(ext_valid), 32'd0);
    check32("rst_readies", {29'b0, fetch_ready, mem_ready, mem_misaligned}, 32'd0);
    check32("rst_bus_error", 32'(bus_error), 32'd0);
    check32("rst_ext_address", ext_address, 32'd0);
    check32("rst_strobe", 32'(ext_write_strobe), 32'd0);
    check32("rst_load_data", mem_load_data, 32'd0);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      run_txn(tv[i].fetch, tv[i].load, tv[i].store, tv[i].addr, tv[i].wdata,
              tv[i].size, tv[i].sgn, tv[i].rdata, 0, o);
      e.addr = tv[i].e_addr; e.wdata = tv[i].e_wdata; e.data = tv[i].e_data;
      e.strb = tv[i].e_strb; e.mis = tv[i].e_mis;
      check_txn($sformatf("vec%0d", i), tv[i].fetch, tv[i].store, o, e, tv[i].chk_data, 0);
    end

    // Long stall: timeout when enabled, otherwise the bus waits
`ifdef BUS_TIMEOUT_EN
    run_txn(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'd2, 1'b0, 32'h5555_AAAA, 1000, o);
    check32("to_nvalid", 32'(o.nvalid), 32'd4);
    check32("to_mem_ready", 32'(o.mr), 32'd1);
    check32("to_bus_error", 32'(o.err), 32'd1);
    check32("to_data", o.data, 32'd0);
`else
    run_txn(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'd2, 1'b0, 32'h5555_AAAA, 20, o);
    check32("wait_nvalid", 32'(o.nvalid), 32'd21);
    check32("wait_bus_error", 32'(o.err), 32'd0);
    check32("wait_data", o.data, 32'h5555_AAAA);
`endif

    // Reset raised during a stalled data access
    @(negedge clk);
    mem_load = 1'b1; mem_address = 32'h0000_0200; mem_size = 2'd2; mem_signed = 1'b0;
    repeat (3) @(negedge clk);
    check32("mid_ext_valid_before", 32'(ext_valid), 32'd1);
    reset = 1'b1;
    #1;
    check32("mid_ext_valid_after", 32'(ext_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_load = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_ready || fetch_ready || ext_valid) saw = 1'b1;
    end
    check32("mid_no_activity", 32'(saw), 32'd0);

    // Round-robin from reset with both requesters held
    @(negedge clk);
    fetch_valid = 1'b1; fetch_address = 32'h0000_0400;
    mem_load = 1'b1; mem_address = 32'h0000_0800; mem_size = 2'd2;
    ext_read_data = 32'h0BAD_F00D;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      ext_ready = ext_valid;
      if (fetch_ready || mem_ready) begin
        check32($sformatf("rr_grant%0d", k), {30'b0, fetch_ready, mem_ready},
                (k % 2 == 0) ? 32'd1 : 32'd2);
        k++;
      end
    end
    check32("rr_done", 32'(k), 32'd4);
    fetch_valid = 1'b0; mem_load = 1'b0; ext_ready = 1'b0;

    // Random single-requester traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      logic        f, l, s, sg;
      logic [1:0]  sz;
      logic [31:0] a, wd, rd;
      int          op, wt;
      op = int'($urandom_range(0, 3));
      f  = (op == 0);
      s  = (op == 2);
      l  = (op == 1) || (op == 3) || (s && $urandom_range(0, 1) == 1);
      if (op == 3) s = 1'b1;
      a  = $urandom;
      if (f) a = a & 32'hFFFF_FFFC;
      wd = $urandom; rd = $urandom;
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      wt = int'($urandom_range(0, 3));
      run_txn(f, l, s, a, wd, sz, sg, rd, wt, o);
      e = model(f, s, a, wd, rd, sz, sg);
      check_txn($sformatf("rnd%0d", n), f, s, o, e, !s || e.mis, wt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter shall be: TIMEOUT_CYCLES, 255, ext_ready wait limit in cycles (1..65535); used only with BUS_TIMEOUT_EN.
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: fetch_valid  in  1  instruction fetch request, held until fetch_ready.
REQ-005 Port: fetch_address  in  32  fetch byte address, word aligned.
REQ-006 Port: fetch_ready  out  1  one-cycle fetch completion pulse.
REQ-007 Port: fetch_data  out  32  fetch result, valid while fetch_ready.
REQ-008 Port: mem_load / mem_store  in  1 each  data request, held until mem_ready; both high is treated as store.
REQ-009 Port: mem_address  in  32  data byte address.
REQ-010 Port: mem_store_data  in  32  store value, right-aligned.
REQ-011 Port: mem_size  in  2  0 byte, 1 half, 2 word; 3 treated as word.
REQ-012 Port: mem_signed  in  1  sign-extend load result.
REQ-013 Port: mem_ready  out  1  one-cycle data completion pulse.
REQ-014 Port: mem_load_data  out  32  formatted load result, valid while mem_ready.
REQ-015 Port: mem_misaligned  out  1  pulses with mem_ready when the access was misaligned.
REQ-016 Port: ext_valid / ext_instruction  out  1 each  bus request; ext_instruction high for fetch.
REQ-017 Port: ext_ready  in  1  bus completion.
REQ-018 Port: ext_address / ext_write_data  out  32 each  word-aligned address, lane-replicated store data.
REQ-019 Port: ext_write_strobe  out  4  byte enables; 0000 for loads and fetches.
REQ-020 Port: ext_read_data  in  32  bus read data, sampled when ext_ready.
REQ-021 Port: bus_error  out  1  timeout pulse with the ready pulse.

Function
REQ-022 FSM states shall be IDLE, FETCH, MEM, RESP.
REQ-023 IDLE: fetch only -> FETCH; mem only -> MEM; both -> grant the requester not granted last (round-robin); none -> stay.
REQ-024 Request, address, size, signed and store data shall be latched on leaving IDLE; ext_* shall be driven from the latches only.
REQ-025 ext_valid shall be 1 exactly in FETCH/MEM; first ext_valid cycle = cycle after request sampled in IDLE.
REQ-026 FETCH/MEM with ext_ready=1 -> RESP, capturing ext_read_data; ext_valid drops next cycle.
REQ-027 RESP shall assert exactly one of fetch_ready/mem_ready for one cycle, then -> IDLE; minimum request-to-ready latency 3 cycles (ext_ready in first bus cycle).
REQ-028 Requester shall drop or change its request the cycle after ready; the arbiter samples again only in IDLE.
REQ-029 Strobe: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111; store data replicated per size.
REQ-030 Load: shift read data right by 8*addr[1:0], mask to size, sign- or zero-extend per mem_signed.
REQ-031 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): MEM -> RESP with no bus cycle, mem_load_data 0, mem_misaligned 1.
REQ-032 Fetch data shall pass unmodified.

Reset
REQ-033 reset shall force immediately: state IDLE, last-grant = FETCH (mem wins first tie), ext_valid 0, all ready/error/misaligned outputs 0, latched data 0, timeout counter 0.
REQ-034 Reset during FETCH/MEM shall abandon the transfer with no ready pulse.

Configuration
REQ-035 With BUS_TIMEOUT_EN defined: a counter clears on entering FETCH/MEM, increments each ext_ready=0 cycle; reaching TIMEOUT_CYCLES -> RESP with data 0 and bus_error 1.
REQ-036 Without BUS_TIMEOUT_EN: no counter; bus_error tied 0; bus waits indefinitely.

Structure
REQ-037 Package bus_pkg shall hold the state encoding and mem_size codes.
REQ-038 Sub-module bus_lane_formatter shall hold the combinational strobe, store replication, load extraction and misalignment check.

Verification
REQ-039 Fetch 0x8000_0000, ext_ready first cycle, data 0x0000_0013 -> ext_instruction 1, strobe 0000, fetch_ready cycle 3, fetch_data 0x0000_0013.
REQ-040 Fetch and load asserted together from reset -> mem first; next tie -> fetch; alternation continues.
REQ-041 Signed byte load addr 0x1003, read 0x8000_0000 -> ext_address 0x1000, mem_load_data 0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-042 Half store 0xBEEF at 0x2002 -> strobe 1100, ext_write_data 0xBEEF_BEEF; word load at 0x2001 -> no ext_valid, mem_misaligned 1.
REQ-043 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, ext_ready held 0 -> ext_valid for 4 cycles, then mem_ready with bus_error 1, data 0.
REQ-044 reset raised during MEM with ext_ready 0 -> ext_valid 0 at once, no mem_ready, next request arbitrated normally.
